// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Host-side valid/ready word channel feeding uart_tx_fifo.
//   tx_data  : word to transmit (DATA_BITS wide)
//   tx_valid : tx_data holds a word to send
//   tx_ready : transmitter FIFO can accept a word this edge
//   master modport: host logic; slave modport: uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an input FIFO. Words arrive on a valid/ready
//   channel, are buffered, and are sent LSB-first as
//   start(0) / DATA_BITS data / optional parity / STOP_BITS stop(1).
//   Consecutive frames are sent with no idle gap between them.
// Ports:
//   uart_clock : clock, rising edge
//   uart_reset : asynchronous reset, active low
//   host       : valid/ready word channel (slave side)
//   uart_d_out : serial line, idle high, registered
//   tx_busy    : a frame is in progress
//   tx_done    : high during the last cycle of each frame's last stop bit
//   fifo_count : number of words currently buffered
module uart_tx_fifo #(
  parameter logic [27:0] CLOCK_FREQ = 28'd100_000_000,
  parameter logic [23:0] BAUD_RATE  = 24'd2_000_000,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 4,
  localparam int         AW         = $clog2(FIFO_DEPTH)
) (
  input  logic           uart_clock,
  input  logic           uart_reset,
  uart_tx_fifo_if.slave  host,
  output logic           uart_d_out,
  output logic           tx_busy,
  output logic           tx_done,
  output logic [AW:0]    fifo_count
);

  localparam logic [27:0]   DIVISOR    = CLOCK_FREQ / {4'd0, BAUD_RATE};
  localparam logic [23:0]   BAUD_LAST  = 24'(DIVISOR - 28'd1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = (PARITY != 0);
  localparam logic          ODD_PARITY = (PARITY == 1);
  localparam logic [AW:0]   DEPTH_VAL  = (AW + 1)'(FIFO_DEPTH);

  // Reject parameter sets the datapath cannot represent.
  generate
    if (DIVISOR < 28'd2 || DIVISOR > 28'h100_0000) begin : g_bad_divisor
      $error("uart_tx_fifo: CLOCK_FREQ/BAUD_RATE must be in 2..2^24");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head_word;

  assign full          = (count_reg == DEPTH_VAL);
  assign empty         = (count_reg == '0);
  assign push          = host.tx_valid && !full;
  assign host.tx_ready = !full;
  assign fifo_count    = count_reg;
  // The head word is captured straight into the shift register on pop,
  // so that register acts as the read register of the buffer.
  assign head_word     = mem[rd_ptr_reg];

  always_ff @(posedge uart_clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= host.tx_data;
    end
  end

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_reg,  state_next;
  logic [23:0]          baud_reg,   baud_next;
  logic [3:0]           bit_reg,    bit_next;
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 parity_reg, parity_next;
  logic                 line_reg,   line_next;
  logic                 bit_end;

  assign bit_end    = (baud_reg == BAUD_LAST);
  assign uart_d_out = line_reg;
  assign tx_busy    = (state_reg != S_IDLE);

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      line_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      line_reg   <= line_next;
    end
  end

  // line_next is the value the line takes for the coming cycle, so the
  // registered output changes on the same edge as the state.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg + 24'd1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    line_next   = line_reg;
    pop         = 1'b0;
    tx_done     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        line_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
          line_next  = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          line_next  = shift_reg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (HAS_PARITY) begin
              state_next = S_PARITY;
              line_next  = parity_reg;
            end else begin
              state_next = S_STOP;
              line_next  = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 4'd1;
            shift_next = shift_reg >> 1;
            line_next  = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_STOP;
          line_next  = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            tx_done  = 1'b1;
            bit_next = '0;
            // Chain straight into the next start bit when a word waits.
            if (!empty) begin
              pop        = 1'b1;
              state_next = S_START;
              line_next  = 1'b0;
            end else begin
              state_next = S_IDLE;
              line_next  = 1'b1;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        baud_next  = '0;
        bit_next   = '0;
        line_next  = 1'b1;
      end
    endcase

    // Parity is fixed at pop time from the whole word.
    if (pop) begin
      shift_next  = head_word;
      parity_next = (^head_word) ^ ODD_PARITY;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo. One 8N1 instance (DIVISOR=10, depth 4) is
//   checked every cycle against a frame-level model; 8E1, 8O1 and 7E2
//   instances are checked against hand-computed frames.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int NB    = 10;
  localparam int TOTAL = NB * DIV;
  localparam int DEPTH = 4;
  localparam int NREC  = 120;

  logic uart_clock = 1'b0;
  logic uart_reset = 1'b0;
  always #5 uart_clock = ~uart_clock;

  uart_tx_fifo_if #(.DATA_BITS(8)) m_if ();
  uart_tx_fifo_if #(.DATA_BITS(8)) e_if ();
  uart_tx_fifo_if #(.DATA_BITS(8)) o_if ();
  uart_tx_fifo_if #(.DATA_BITS(7)) s_if ();

  logic       line0, line1, line2, line3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic [2:0] cnt0,  cnt1,  cnt2,  cnt3;

  uart_tx_fifo #(.CLOCK_FREQ(28'd100_000_000), .BAUD_RATE(24'd10_000_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .uart_clock(uart_clock), .uart_reset(uart_reset), .host(m_if.slave),
    .uart_d_out(line0), .tx_busy(busy0), .tx_done(done0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLOCK_FREQ(28'd100_000_000), .BAUD_RATE(24'd10_000_000),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .uart_clock(uart_clock), .uart_reset(uart_reset), .host(e_if.slave),
    .uart_d_out(line1), .tx_busy(busy1), .tx_done(done1), .fifo_count(cnt1));

  uart_tx_fifo #(.CLOCK_FREQ(28'd100_000_000), .BAUD_RATE(24'd10_000_000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .uart_clock(uart_clock), .uart_reset(uart_reset), .host(o_if.slave),
    .uart_d_out(line2), .tx_busy(busy2), .tx_done(done2), .fifo_count(cnt2));

  uart_tx_fifo #(.CLOCK_FREQ(28'd100_000_000), .BAUD_RATE(24'd10_000_000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
    .uart_clock(uart_clock), .uart_reset(uart_reset), .host(s_if.slave),
    .uart_d_out(line3), .tx_busy(busy3), .tx_done(done3), .fifo_count(cnt3));

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // ------------------------------------------------- frame-level model
  // The model knows only: a word enters when valid and fewer than DEPTH
  // are stored; a word leaves when the line is free or the current frame
  // is in its last cycle; a frame is the fixed bit list held DIV cycles each.
  logic [7:0]    m_q[$];
  bit            m_active  = 1'b0;
  int            m_elapsed = 0;
  logic [NB-1:0] m_frame   = '1;

  function automatic logic [NB-1:0] frame_of(input logic [7:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  initial begin
    bit do_pop, do_acc;
    forever begin
      @(posedge uart_clock);
      if (!uart_reset) begin
        m_q.delete();
        m_active  = 1'b0;
        m_elapsed = 0;
      end else begin
        do_pop = (m_q.size() > 0) && (!m_active || m_elapsed == TOTAL - 1);
        do_acc = m_if.tx_valid && (m_q.size() < DEPTH);
        if (m_active) begin
          m_elapsed++;
          if (m_elapsed == TOTAL) m_active = 1'b0;
        end
        if (do_pop) begin
          m_frame   = frame_of(m_q.pop_front());
          m_active  = 1'b1;
          m_elapsed = 0;
        end
        if (do_acc) m_q.push_back(m_if.tx_data);
      end
    end
  end

  // Per-cycle compare of the 8N1 instance, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge uart_clock);
      if (!uart_reset) begin
        chk("rst_line",  int'(line0), 1);
        chk("rst_busy",  int'(busy0), 0);
        chk("rst_done",  int'(done0), 0);
        chk("rst_count", int'(cnt0),  0);
        chk("rst_ready", int'(m_if.tx_ready), 1);
      end else begin
        if (done0) done_cnt++;
        chk("line",  int'(line0), m_active ? int'(m_frame[m_elapsed / DIV]) : 1);
        chk("busy",  int'(busy0), int'(m_active));
        chk("done",  int'(done0), int'(m_active && m_elapsed == TOTAL - 1));
        chk("count", int'(cnt0),  m_q.size());
        chk("ready", int'(m_if.tx_ready), int'(m_q.size() < DEPTH));
      end
    end
  end

  // ------------------------------------------------- directed helpers
  logic hl [4][NREC];
  logic hd [4][NREC];
  logic hb [4][NREC];
  int   hc [4][NREC];

  task automatic rec(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge uart_clock);
      hl[0][k] = line0; hl[1][k] = line1; hl[2][k] = line2; hl[3][k] = line3;
      hd[0][k] = done0; hd[1][k] = done1; hd[2][k] = done2; hd[3][k] = done3;
      hb[0][k] = busy0; hb[1][k] = busy1; hb[2][k] = busy2; hb[3][k] = busy3;
      hc[0][k] = int'(cnt0); hc[1][k] = int'(cnt1);
      hc[2][k] = int'(cnt2); hc[3][k] = int'(cnt3);
    end
  endtask

  // Sample 0 is the falling edge right after the accept edge.
  task automatic check_frame(input int idx, input string nm, input int nbits,
                             input int exp_frame);
    int v, first, ndone;
    v = 0; first = -1; ndone = 0;
    for (int j = 0; j < nbits; j++)
      if (hl[idx][1 + j * DIV + DIV / 2]) v |= (1 << j);
    for (int k = 0; k < NREC; k++)
      if (hd[idx][k]) begin
        ndone++;
        if (first < 0) first = k;
      end
    chk({nm, "_count_after_accept"}, hc[idx][0], 1);
    chk({nm, "_count_after_pop"},    hc[idx][1], 0);
    chk({nm, "_idle_before"},        int'(hl[idx][0]), 1);
    chk({nm, "_start_edge"},         int'(hl[idx][1]), 0);
    chk({nm, "_busy_in_frame"},      int'(hb[idx][1]), 1);
    chk({nm, "_frame_bits"},         v, exp_frame);
    chk({nm, "_done_cycle"},         first, nbits * DIV);
    chk({nm, "_done_pulses"},        ndone, 1);
    chk({nm, "_idle_after"},         int'(hl[idx][nbits * DIV + 1]), 1);
    chk({nm, "_busy_after"},         int'(hb[idx][nbits * DIV + 1]), 0);
  endtask

  // Presents a word on the 8N1 channel until accepted; leaves valid high.
  task automatic push_main(input logic [7:0] w);
    bit acc;
    int guard;
    if (!m_if.tx_valid) begin
      @(posedge uart_clock);
      #1;
    end
    m_if.tx_data  = w;
    m_if.tx_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 1000) begin
      @(negedge uart_clock);
      acc = m_if.tx_ready;
      @(posedge uart_clock);
      guard++;
    end
    #1;
    chk("push_accepted", int'(acc), 1);
  endtask

  task automatic wait_done(input string nm);
    int guard;
    guard = 0;
    do begin
      @(negedge uart_clock);
      guard++;
    end while (!done0 && guard < 2000);
    chk({nm, "_done_seen"}, int'(done0), 1);
  endtask

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    do begin
      @(negedge uart_clock);
      guard++;
    end while ((busy0 || cnt0 != 3'd0) && guard < 3000);
    chk({nm, "_idle"}, int'(busy0), 0);
  endtask

  // ------------------------------------------------------- stimulus
  initial begin
    logic [7:0] full_words [6];
    int base, lows;
    full_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    m_if.tx_valid = 1'b0; m_if.tx_data = '0;
    e_if.tx_valid = 1'b0; e_if.tx_data = '0;
    o_if.tx_valid = 1'b0; o_if.tx_data = '0;
    s_if.tx_valid = 1'b0; s_if.tx_data = '0;

    repeat (3) @(negedge uart_clock);
    @(posedge uart_clock);
    #1 uart_reset = 1'b1;

    // Basic 8N1 frame plus the three parity configurations, one accept edge.
    @(posedge uart_clock);
    #1;
    chk("8e1_ready", int'(e_if.tx_ready), 1);
    chk("8o1_ready", int'(o_if.tx_ready), 1);
    chk("7e2_ready", int'(s_if.tx_ready), 1);
    m_if.tx_data = 8'hA5; m_if.tx_valid = 1'b1;
    e_if.tx_data = 8'hA5; e_if.tx_valid = 1'b1;
    o_if.tx_data = 8'hA5; o_if.tx_valid = 1'b1;
    s_if.tx_data = 7'h7F; s_if.tx_valid = 1'b1;
    @(posedge uart_clock);
    #1;
    m_if.tx_valid = 1'b0; e_if.tx_valid = 1'b0;
    o_if.tx_valid = 1'b0; s_if.tx_valid = 1'b0;
    rec(NREC);
    check_frame(0, "8n1_a5", 10, 'h34A);
    chk("8n1_start_low_last", int'(hl[0][10]), 0);
    chk("8n1_first_data_bit", int'(hl[0][11]), 1);
    check_frame(1, "8e1_a5", 11, 'h54A);
    check_frame(2, "8o1_a5", 11, 'h74A);
    check_frame(3, "7e2_7f", 11, 'h7FE);

    // FIFO full: valid held across six words.
    base = done_cnt;
    for (int i = 0; i < 5; i++) push_main(full_words[i]);
    @(negedge uart_clock);
    chk("full_count", int'(cnt0), 4);
    chk("full_ready", int'(m_if.tx_ready), 0);
    push_main(full_words[5]);
    m_if.tx_valid = 1'b0;
    wait_idle("full");
    chk("full_frames", done_cnt - base, 6);

    // Back-to-back: 0x00 and 0xFF queued behind a frame in flight.
    push_main(8'h3C);
    push_main(8'h00);
    push_main(8'hFF);
    m_if.tx_valid = 1'b0;
    @(negedge uart_clock);
    chk("b2b_count_2", int'(cnt0), 2);
    wait_done("b2b_first");
    chk("b2b_stop_high", int'(line0), 1);
    @(negedge uart_clock);
    chk("b2b_count_1", int'(cnt0), 1);
    chk("b2b_start_00", int'(line0), 0);
    wait_done("b2b_00");
    @(negedge uart_clock);
    chk("b2b_count_0", int'(cnt0), 0);
    chk("b2b_start_ff", int'(line0), 0);
    wait_idle("b2b");

    // Push on the same edge as the pop at a frame end, count already 2.
    push_main(8'h3C);
    push_main(8'h81);
    push_main(8'h7E);
    m_if.tx_valid = 1'b0;
    wait_done("simul");
    chk("simul_count_before", int'(cnt0), 2);
    m_if.tx_data  = 8'h99;
    m_if.tx_valid = 1'b1;
    @(posedge uart_clock);
    #1 m_if.tx_valid = 1'b0;
    @(negedge uart_clock);
    chk("simul_count_after", int'(cnt0), 2);
    wait_idle("simul");

    // Reset in the middle of the 4th data bit of 0x55 (a 0 bit).
    push_main(8'h55);
    m_if.tx_valid = 1'b0;
    repeat (46) @(negedge uart_clock);
    chk("rstmid_bit3_low", int'(line0), 0);
    #1 uart_reset = 1'b0;
    #1;
    chk("rstmid_async_line", int'(line0), 1);
    chk("rstmid_async_busy", int'(busy0), 0);
    chk("rstmid_async_count", int'(cnt0), 0);
    repeat (3) @(posedge uart_clock);
    #1 uart_reset = 1'b1;
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge uart_clock);
      if (!line0) lows++;
    end
    chk("rstmid_line_stays_high", lows, 0);
    chk("rstmid_busy_after", int'(busy0), 0);
    chk("rstmid_count_after", int'(cnt0), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. Replaces the single-byte start-pulse transmitter in the MRAM data-collection path. Host logic streams words via valid/ready; the block serialises them LSB-first with configurable data width, parity and stop bits. Back-to-back frames go out with no idle gap between them.

## Interface
- CLOCK_FREQ, 100000000: uart_clock frequency, Hz (28-bit).
- BAUD_RATE, 2000000: line rate, bit/s (24-bit). DIVISOR = CLOCK_FREQ/BAUD_RATE (integer). DIVISOR < 2 is an elaboration error.
- DATA_BITS, 8: data bits per frame, legal 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Value 3 is an elaboration error.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: entries, power of two, ≥ 2. AW = $clog2(FIFO_DEPTH).
- uart_clock  in  1  clock, all logic rising-edge.
- uart_reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO not full. A word is accepted on an edge where tx_valid && tx_ready.
- uart_d_out  out  1  serial line, idle high, registered.
- tx_busy  out  1  frame in progress (FSM not IDLE).
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- fifo_count  out  AW+1  entries currently stored.

## Operation
- FIFO: circular buffer with AW-bit read/write pointers that wrap modulo FIFO_DEPTH. Count is AW+1 bits. full = (count == FIFO_DEPTH). empty = (count == 0).
- Push when tx_valid && !full. Push while full is ignored; the word is not lost because the host holds it under valid/ready.
- Pop only by the FSM. A push and a pop on the same edge leave count unchanged.
- Frame format: start bit (0), DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits (1). NBITS = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Parity: even parity = XOR of the data bits. Odd parity = its inverse. Computed when the word is popped.
- The FSM has five states:
  - IDLE: line high. If !empty: pop, load shift register and parity, go to START.
  - START: line low for DIVISOR cycles, then go to DATA.
  - DATA: one bit per DIVISOR cycles. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: one bit period, then go to STOP.
  - STOP: line high for STOP_BITS×DIVISOR cycles. On the final cycle, pulse tx_done. Then, if !empty, pop and go directly to START; else go to IDLE.
- Baud counter: 24-bit, counts 0..DIVISOR-1 and clears on every bit boundary. Each bit lasts exactly DIVISOR cycles, not DIVISOR+1.
- Unused encodings in any state go to IDLE with the line high.

## Timing
- Reset values: uart_d_out=1, tx_ready=1, tx_busy=0, tx_done=0, fifo_count=0. Reset also clears the FIFO pointers and the FSM enters IDLE.
- Reset mid-frame: the line goes high asynchronously and FIFO contents are discarded. After reset release, no partial frame resumes.
- Latency with the FSM idle and the FIFO empty:
  - Word accepted at edge E0; fifo_count=1 after E0.
  - At E1 the FSM pops (fifo_count=0) and uart_d_out falls to 0 after E1.
- Frame duration is NBITS×DIVISOR cycles, measured from the start-bit falling edge to the end of the last stop bit.
- tx_done is high for exactly the last cycle of the last stop bit.
- With the FIFO non-empty at the end of a stop bit, the next start bit begins on the following cycle. There is no idle gap.
- tx_ready is derived combinationally from the registered count, so it deasserts in the cycle after the accepting edge that fills the FIFO.

## Test plan
- Basic frame, 8N1, DIVISOR=10 (100 MHz/10 Mbaud): push 0xA5. Expect:
  - line low 10 cycles;
  - then bits 1,0,1,0,0,1,0,1, 10 cycles each;
  - stop high 10 cycles;
  - tx_done pulse at cycle 100 after the start edge;
  - start edge exactly 1 cycle after the accept edge.
- Parity, 8E1 then 8O1: push 0xA5 (four ones). Expect parity bit 0 (even) and 1 (odd). Frame is 110 cycles. 7E2 with 0x7F gives parity 1 and two stop periods; frame is 110 cycles.
- FIFO full, FIFO_DEPTH=4, tx_valid held high with 6 words: during the first frame only 5 words are accepted (1 popped, 4 stored); tx_ready=0 with fifo_count=4. The remaining word is accepted after the next pop. All 6 frames are transmitted in order.
- Back-to-back: push 0x00 then 0xFF. The second start bit follows the first frame's stop bit with no high gap beyond one stop period. fifo_count reads 2→1→0 on the two pops.
- Simultaneous push/pop: with fifo_count=2 at a frame end, push on the pop edge. fifo_count stays 2.
- Reset mid-frame: assert uart_reset during the 4th data bit of 0x55. uart_d_out=1 with no clock edge. After release, fifo_count=0, tx_busy=0, and the line stays high until a new push.
